// File: rtl/aspiradora_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// aspiradora_pkg : state encoding shared by the vacuum-cleaner controller
// Rev 2.0 - six-state machine with evade, return and charge
// ---------------------------------------------------------------------------
package aspiradora_pkg;

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_IDLE   = 3'd1,
    S_CLEAN  = 3'd2,
    S_EVADE  = 3'd3,
    S_RETURN = 3'd4,
    S_CHARGE = 3'd5
  } state_e;

  localparam logic [2:0] ST_ILLEGAL_6 = 3'd6;
  localparam logic [2:0] ST_ILLEGAL_7 = 3'd7;

endpackage
`default_nettype wire

// File: rtl/sw_debounce.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sw_debounce : 2-flop synchroniser followed by a stable-count debouncer
// Rev 2.0
// ---------------------------------------------------------------------------
module sw_debounce #(
  parameter int CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sw,
  output logic o_sw
);

  localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any cycle where the synchronised value matches the output restarts the count
  always_comb begin
    out_d = out_q;
    cnt_d = '0;
    if (sync2_q != out_q) begin
      if (cnt_q == CNT_TOP) begin
        out_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      out_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= i_sw;
      sync2_q <= sync1_q;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_sw = out_q;

endmodule
`default_nettype wire

// File: rtl/aspiradora_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// aspiradora_ctrl : Moore FSM vacuum controller with evade timer and battery
// Rev 2.0
// ---------------------------------------------------------------------------
module aspiradora_ctrl
  import aspiradora_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int EVADE_CYCLES    = 50_000_000,
  parameter int RETURN_CYCLES   = 200_000_000,
  parameter int BATT_W          = 4,
  parameter int BATT_MAX        = 15,
  parameter int LOW_THR         = 3,
  parameter int DRAIN_DIV       = 100_000_000,
  parameter int CHARGE_DIV      = 50_000_000
) (
  input  logic              CLK100MHZ,
  input  logic              CPU_RESETN,
  input  logic [3:0]        SW,
  output logic [2:0]        led,
  output logic [BATT_W-1:0] batt_lvl
);

  localparam int TMR_MAX = (EVADE_CYCLES > RETURN_CYCLES) ? EVADE_CYCLES : RETURN_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int PS_MAX  = (DRAIN_DIV > CHARGE_DIV) ? DRAIN_DIV : CHARGE_DIV;
  localparam int PS_W    = $clog2(PS_MAX + 1);

  localparam logic [TMR_W-1:0]  EVADE_LD   = TMR_W'(EVADE_CYCLES - 1);
  localparam logic [TMR_W-1:0]  RETURN_LD  = TMR_W'(RETURN_CYCLES - 1);
  localparam logic [PS_W-1:0]   DRAIN_TOP  = PS_W'(DRAIN_DIV - 1);
  localparam logic [PS_W-1:0]   CHARGE_TOP = PS_W'(CHARGE_DIV - 1);
  localparam logic [BATT_W-1:0] BATT_FULL  = BATT_W'(BATT_MAX);
  localparam logic [BATT_W-1:0] BATT_LOW   = BATT_W'(LOW_THR);

  logic [3:0] sw_db;
  logic       pw, on, cl, ob;

  for (genvar i = 0; i < 4; i++) begin : g_sw
    sw_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk   (CLK100MHZ),
      .rst_n (CPU_RESETN),
      .i_sw  (SW[i]),
      .o_sw  (sw_db[i])
    );
  end

  assign pw = sw_db[0];
  assign on = sw_db[1];
  assign cl = sw_db[2];
  assign ob = sw_db[3];

  state_e            state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [PS_W-1:0]   presc_q, presc_d;
  logic [BATT_W-1:0] batt_q, batt_d;
  logic              timer_zero, batt_low;

  assign timer_zero = (timer_q == '0);
  assign batt_low   = (batt_q <= BATT_LOW);

  always_comb begin
    state_d = state_q;
    timer_d = timer_zero ? timer_q : timer_q - TMR_W'(1);
    presc_d = '0;
    batt_d  = batt_q;

    case (state_q)
      S_OFF:    if (on) state_d = S_IDLE;
      S_IDLE:   if (cl) state_d = batt_low ? S_RETURN : S_CLEAN;
      S_CLEAN: begin
        if (batt_low)  state_d = S_RETURN;
        else if (ob)   state_d = S_EVADE;
        else if (!cl)  state_d = S_IDLE;
      end
      S_EVADE: begin
        if (timer_zero) begin
          if (ob)            timer_d = EVADE_LD;
          else if (batt_low) state_d = S_RETURN;
          else if (cl)       state_d = S_CLEAN;
          else               state_d = S_IDLE;
        end
      end
      S_RETURN: if (timer_zero) state_d = S_CHARGE;
      S_CHARGE: if (batt_q == BATT_FULL) state_d = S_IDLE;
      ST_ILLEGAL_6, ST_ILLEGAL_7: state_d = S_OFF;
      default:  state_d = S_OFF;
    endcase

    if (pw) state_d = S_OFF;

    case (state_q)
      S_CLEAN, S_EVADE, S_RETURN: begin
        if (presc_q == DRAIN_TOP) begin
          if (batt_q != '0) batt_d = batt_q - BATT_W'(1);
        end else begin
          presc_d = presc_q + PS_W'(1);
        end
      end
      S_CHARGE: begin
        if (presc_q == CHARGE_TOP) begin
          if (batt_q < BATT_FULL) batt_d = batt_q + BATT_W'(1);
        end else begin
          presc_d = presc_q + PS_W'(1);
        end
      end
      default: presc_d = '0;
    endcase

    // Entering a state restarts its prescaler and loads that state's timer
    if (state_d != state_q) begin
      presc_d = '0;
      if (state_d == S_EVADE)       timer_d = EVADE_LD;
      else if (state_d == S_RETURN) timer_d = RETURN_LD;
      else                          timer_d = '0;
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      state_q <= S_OFF;
      timer_q <= '0;
      presc_q <= '0;
      batt_q  <= BATT_FULL;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      presc_q <= presc_d;
      batt_q  <= batt_d;
    end
  end

  assign led      = state_q;
  assign batt_lvl = batt_q;

endmodule
`default_nettype wire
